alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Execute-to-writeback stage that consumes the ALU's three result buses (adder, shifter, comparator) alongside the decoded instruction.
- Selects the architectural result and resolves branch and jump outcomes.
- Holds results in a 2-entry skid buffer with a valid/ready handshake toward writeback.
- The skid buffer keeps in_ready registered, so the ALU/decode side never sees combinational backpressure from writeback.

Parameters:
- XLEN, 32, datapath width; all data ports are XLEN bits.
- DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream presents an instruction this cycle.
- in_ready  out  1  stage can accept; registered.
- opcode  in  7  RV32I opcode.
- funct3  in  3  instruction funct3.
- rd  in  5  destination register.
- pc  in  XLEN  instruction address.
- imm  in  XLEN  sign-extended immediate.
- rs1_val  in  XLEN  register operand 1.
- rs2_val  in  XLEN  register operand 2.
- adder_rsv  in  XLEN  ALU adder/logic result.
- shifter_rsv  in  XLEN  ALU shifter result.
- comparator_rsv  in  XLEN  ALU slt/sltu result.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts head entry.
- wb_en  out  1  head entry writes the register file.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  result value.
- redirect  out  1  head entry changes control flow.
- redirect_pc  out  XLEN  new PC when redirect=1.
- illegal  out  1  head opcode unrecognised.

Behaviour:
- Reset (async, rst_n=0): both entries invalid, count=0, in_ready=1, out_valid=0. wb_en, redirect and illegal read 0; wb_rd, wb_data and redirect_pc read 0.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready. Both in the same cycle leaves count unchanged. FIFO order is preserved.
- in_ready is registered and equals (count_next < 2), i.e. the value after this cycle's push/pop.
- Latency: an entry accepted into an empty buffer appears at out_valid on the next cycle. Throughput is 1 per cycle while out_ready=1.
- Full (count=2): in_ready=0. in_valid is ignored, and any held inputs are not sampled.
- Empty: out_valid=0 and outputs are driven 0.
- Result selection is combinational at input and stored per entry:
  - OP (0110011) and OP-IMM (0010011): funct3 001/101 select shifter_rsv; 010/011 select comparator_rsv; otherwise adder_rsv. wb_en=(rd!=0).
  - LUI (0110111): imm, wb_en=(rd!=0).
  - AUIPC (0010111): pc+imm modulo 2^32, wb_en=(rd!=0).
  - JAL (1101111): data pc+4, redirect=1, redirect_pc=pc+imm.
  - JALR (1100111): data pc+4, redirect=1, redirect_pc=(rs1_val+imm)&~1.
  - BRANCH (1100011): wb_en=0, redirect_pc=pc+imm. redirect is determined by funct3:
    - 000 eq
    - 001 ne
    - 100 signed lt
    - 101 signed ge
    - 110 unsigned lt
    - 111 unsigned ge
    - 010/011: redirect=0 and illegal=1.
  - LOAD (0000011) and STORE (0100011): wb_data=adder_rsv as the effective address, wb_en=0. Memory handles the writeback.
  - Any other opcode: illegal=1, wb_en=0, redirect=0, wb_data=0.
- All PC arithmetic wraps at 2^32. pc+4 at 0xFFFFFFFC yields 0.
- rd=0 never asserts wb_en.
- Async reset mid-operation discards all entries immediately. Nothing is emitted after deassertion until a new accept.

Test Plan:
- ADD rd=5, adder_rsv=0x00000007, out_ready=1 -> next cycle out_valid=1, wb_en=1, wb_rd=5, wb_data=0x7, redirect=0.
- SRA funct3=101, shifter_rsv=0xFFFFFFF0, comparator_rsv=1 -> wb_data=0xFFFFFFF0. SLTU funct3=011 -> wb_data=comparator_rsv.
- BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 -> redirect=1, redirect_pc=0xF8. BLTU with the same operands -> redirect=0. Both cases wb_en=0.
- JALR with rs1=0x1001, imm=2, pc=0xFFFFFFFC, rd=1 -> wb_data=0x0, redirect_pc=0x1002.
- out_ready=0 with 3 back-to-back in_valid -> 2 accepted, in_ready=0 on the cycle after the 2nd accept. Raising out_ready drains in order, and in_ready returns 1 one cycle after the first pop.
- Reset pulse with 2 entries held -> out_valid=0 and in_ready=1 immediately. Opcode 0x7F -> illegal=1, wb_en=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: picks the architectural result from the ALU buses,
// resolves branch/jump outcomes and queues them in a 2-entry skid buffer.
module alu_result_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] adder_rsv,
    input  logic [XLEN-1:0] shifter_rsv,
    input  logic [XLEN-1:0] comparator_rsv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Decoded result of the instruction currently on the input side
    logic            sel_wb_en;
    logic [XLEN-1:0] sel_data;
    logic            sel_redirect;
    logic [XLEN-1:0] sel_redirect_pc;
    logic            sel_illegal;

    logic            rd_nonzero;
    logic            br_eq;
    logic            br_lt;
    logic            br_ltu;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] rs1_plus_imm;

    assign rd_nonzero   = (rd != 5'd0);
    assign br_eq        = (rs1_val == rs2_val);
    assign br_lt        = ($signed(rs1_val) < $signed(rs2_val));
    assign br_ltu       = (rs1_val < rs2_val);
    assign pc_plus4     = pc + XLEN'(4);
    assign pc_plus_imm  = pc + imm;
    assign rs1_plus_imm = rs1_val + imm;

    always_comb begin
        sel_wb_en       = 1'b0;
        sel_data        = '0;
        sel_redirect    = 1'b0;
        sel_redirect_pc = '0;
        sel_illegal     = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                sel_wb_en = rd_nonzero;
                case (funct3)
                    3'b001, 3'b101: sel_data = shifter_rsv;
                    3'b010, 3'b011: sel_data = comparator_rsv;
                    default:        sel_data = adder_rsv;
                endcase
            end
            OPC_LUI: begin
                sel_wb_en = rd_nonzero;
                sel_data  = imm;
            end
            OPC_AUIPC: begin
                sel_wb_en = rd_nonzero;
                sel_data  = pc_plus_imm;
            end
            OPC_JAL: begin
                sel_wb_en       = rd_nonzero;
                sel_data        = pc_plus4;
                sel_redirect    = 1'b1;
                sel_redirect_pc = pc_plus_imm;
            end
            OPC_JALR: begin
                sel_wb_en       = rd_nonzero;
                sel_data        = pc_plus4;
                sel_redirect    = 1'b1;
                sel_redirect_pc = {rs1_plus_imm[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                sel_redirect_pc = pc_plus_imm;
                case (funct3)
                    3'b000:  sel_redirect = br_eq;
                    3'b001:  sel_redirect = !br_eq;
                    3'b100:  sel_redirect = br_lt;
                    3'b101:  sel_redirect = !br_lt;
                    3'b110:  sel_redirect = br_ltu;
                    3'b111:  sel_redirect = !br_ltu;
                    default: sel_illegal  = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                // Effective address travels on to the memory stage
                sel_data = adder_rsv;
            end
            default: sel_illegal = 1'b1;
        endcase
    end

    // Skid buffer control
    logic       in_ready_reg;
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic       push;
    logic       pop;

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            in_ready_reg <= 1'b1;
        end else begin
            count_reg    <= count_next;
            in_ready_reg <= (count_next < 2'(DEPTH));
            if (push) wr_ptr_reg <= !wr_ptr_reg;
            if (pop)  rd_ptr_reg <= !rd_ptr_reg;
        end
    end

    // Entry storage
    logic            ent_wb_en       [DEPTH];
    logic [4:0]      ent_rd          [DEPTH];
    logic [XLEN-1:0] ent_data        [DEPTH];
    logic            ent_redirect    [DEPTH];
    logic [XLEN-1:0] ent_redirect_pc [DEPTH];
    logic            ent_illegal     [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ent_wb_en[gi]       <= 1'b0;
                    ent_rd[gi]          <= 5'd0;
                    ent_data[gi]        <= '0;
                    ent_redirect[gi]    <= 1'b0;
                    ent_redirect_pc[gi] <= '0;
                    ent_illegal[gi]     <= 1'b0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    ent_wb_en[gi]       <= sel_wb_en;
                    ent_rd[gi]          <= rd;
                    ent_data[gi]        <= sel_data;
                    ent_redirect[gi]    <= sel_redirect;
                    ent_redirect_pc[gi] <= sel_redirect_pc;
                    ent_illegal[gi]     <= sel_illegal;
                end
            end
        end
    endgenerate

    // Head entry is presented only while valid; empty buffer drives zeros
    assign in_ready    = in_ready_reg;
    assign out_valid   = (count_reg != 2'd0);
    assign wb_en       = out_valid ? ent_wb_en[rd_ptr_reg]       : 1'b0;
    assign wb_rd       = out_valid ? ent_rd[rd_ptr_reg]          : 5'd0;
    assign wb_data     = out_valid ? ent_data[rd_ptr_reg]        : '0;
    assign redirect    = out_valid ? ent_redirect[rd_ptr_reg]    : 1'b0;
    assign redirect_pc = out_valid ? ent_redirect_pc[rd_ptr_reg] : '0;
    assign illegal     = out_valid ? ent_illegal[rd_ptr_reg]     : 1'b0;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: decode results, backpressure, reset.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] pc = '0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [31:0] adder_rsv = '0;
    logic [31:0] shifter_rsv = '0;
    logic [31:0] comparator_rsv = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .pc(pc), .imm(imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .adder_rsv(adder_rsv), .shifter_rsv(shifter_rsv), .comparator_rsv(comparator_rsv),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdi,
                         input logic [31:0] pci, input logic [31:0] immi,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] addv, input logic [31:0] shv, input logic [31:0] cmpv);
        opcode = opc; funct3 = f3; rd = rdi; pc = pci; imm = immi;
        rs1_val = r1; rs2_val = r2;
        adder_rsv = addv; shifter_rsv = shv; comparator_rsv = cmpv;
        in_valid = 1'b1;
    endtask

    // Present one instruction at a negedge, let it be accepted, then stop driving
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdi,
                        input logic [31:0] pci, input logic [31:0] immi,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] addv, input logic [31:0] shv, input logic [31:0] cmpv);
        drive(opc, f3, rdi, pci, immi, r1, r2, addv, shv, cmpv);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic we, input logic [4:0] wrd,
                            input logic [31:0] d, input logic rdr, input logic [31:0] rpc,
                            input logic ill);
        chk({tag, ".out_valid"},   32'(out_valid),   32'(v));
        chk({tag, ".wb_en"},       32'(wb_en),       32'(we));
        chk({tag, ".wb_rd"},       32'(wb_rd),       32'(wrd));
        chk({tag, ".wb_data"},     wb_data,          d);
        chk({tag, ".redirect"},    32'(redirect),    32'(rdr));
        chk({tag, ".redirect_pc"}, redirect_pc,      rpc);
        chk({tag, ".illegal"},     32'(illegal),     32'(ill));
        $display("txn %s: v=%0b wb_en=%0b rd=%0d data=%08h redir=%0b rpc=%08h ill=%0b",
                 tag, out_valid, wb_en, wb_rd, wb_data, redirect, redirect_pc, illegal);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_head("rst", 0, 0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        send(7'b0110011, 3'b000, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7, 32'h0, 32'h0);
        chk_head("add", 1, 1, 5, 32'h7, 0, 32'h0, 0);

        send(7'b0110011, 3'b101, 5'd6, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'hFFFF_FFF0, 32'h1);
        chk_head("sra", 1, 1, 6, 32'hFFFF_FFF0, 0, 32'h0, 0);

        send(7'b0010011, 3'b011, 5'd7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'hFFFF_FFF0, 32'h1);
        chk_head("sltiu", 1, 1, 7, 32'h1, 0, 32'h0, 0);

        send(7'b1100011, 3'b100, 5'd0, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0);
        chk_head("blt", 1, 0, 0, 32'h0, 1, 32'h0000_00F8, 0);

        send(7'b1100011, 3'b110, 5'd0, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0);
        chk_head("bltu", 1, 0, 0, 32'h0, 0, 32'h0000_00F8, 0);

        send(7'b1100011, 3'b000, 5'd0, 32'h40, 32'h20, 32'h55, 32'h55, 32'h0, 32'h0, 32'h0);
        chk_head("beq", 1, 0, 0, 32'h0, 1, 32'h60, 0);

        send(7'b1100011, 3'b001, 5'd0, 32'h40, 32'h20, 32'h55, 32'h55, 32'h0, 32'h0, 32'h0);
        chk_head("bne", 1, 0, 0, 32'h0, 0, 32'h60, 0);

        send(7'b1100011, 3'b010, 5'd0, 32'h40, 32'h20, 32'h55, 32'h55, 32'h0, 32'h0, 32'h0);
        chk_head("br010", 1, 0, 0, 32'h0, 0, 32'h60, 1);

        send(7'b1100111, 3'b000, 5'd1, 32'hFFFF_FFFC, 32'h2, 32'h1001, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_head("jalr", 1, 1, 1, 32'h0, 1, 32'h1002, 0);

        send(7'b1101111, 3'b000, 5'd0, 32'h200, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_head("jal_x0", 1, 0, 0, 32'h204, 1, 32'h210, 0);

        send(7'b0110111, 3'b000, 5'd3, 32'h0, 32'h1234_5000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_head("lui", 1, 1, 3, 32'h1234_5000, 0, 32'h0, 0);

        send(7'b0010111, 3'b000, 5'd8, 32'hFFFF_F000, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk_head("auipc", 1, 1, 8, 32'h0000_1000, 0, 32'h0, 0);

        send(7'b0000011, 3'b010, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h40, 32'h0, 32'h0);
        chk_head("load", 1, 0, 4, 32'h40, 0, 32'h0, 0);

        send(7'b1111111, 3'b000, 5'd9, 32'h0, 32'h0, 32'h0, 32'h0, 32'h99, 32'h0, 32'h0);
        chk_head("illegal", 1, 0, 9, 32'h0, 0, 32'h0, 1);

        @(posedge clk);
        @(negedge clk);
        chk_head("drained", 0, 0, 0, 32'h0, 0, 32'h0, 0);

        // Backpressure: three back-to-back offers, only two fit
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 5'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.in_ready_after1", 32'(in_ready), 32'd1);
        drive(7'b0110011, 3'b000, 5'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'hB, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.in_ready_full", 32'(in_ready), 32'd0);
        chk_head("bp.headA", 1, 1, 1, 32'hA, 0, 32'h0, 0);
        drive(7'b0110011, 3'b000, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.in_ready_held", 32'(in_ready), 32'd0);
        chk_head("bp.stillA", 1, 1, 1, 32'hA, 0, 32'h0, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.in_ready_after_pop", 32'(in_ready), 32'd1);
        chk_head("bp.headB", 1, 1, 2, 32'hB, 0, 32'h0, 0);
        @(posedge clk);
        @(negedge clk);
        chk_head("bp.empty", 0, 0, 0, 32'h0, 0, 32'h0, 0);

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        send(7'b0110011, 3'b000, 5'd10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h0, 32'h0);
        send(7'b0110011, 3'b000, 5'd11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22, 32'h0, 32'h0);
        chk("rst2.full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.in_ready", 32'(in_ready), 32'd1);
        chk_head("rst2", 0, 0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_head("rst2.after", 0, 0, 0, 32'h0, 0, 32'h0, 0);

        send(7'b1111111, 3'b000, 5'd12, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0);
        chk_head("op7f", 1, 0, 12, 32'h0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
